// File: rtl/my_pkg.sv
// Shared RV32I decode definitions: operand width, major opcodes, ALU ops, ID/EX payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package my_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1_val;
        logic [DATA_WIDTH-1:0] rs2_val;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        alu_op_t               alu_op;
        logic                  wr_en;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  is_jump;
        logic                  illegal;
    } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks I/S/B/U/J layout from the opcode and sign-extends.
// Latency: combinational.
// Backpressure: none (pure function of the instruction word).
// Ports: insn_i (instruction word), imm_o (sign-extended immediate, 0 for R/unknown).
module imm_gen
    import my_pkg::*;
(
    input  logic [31:0]           insn_i,
    output logic [DATA_WIDTH-1:0] imm_o
);

    logic [6:0] opcode;
    assign opcode = insn_i[6:0];

    always_comb begin
        imm_o = '0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
            OPC_STORE:
                imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            // B and J scramble the offset bits and drop bit0 (always 0).
            OPC_BRANCH:
                imm_o = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {insn_i[31:12], 12'h000};
            OPC_JAL:
                imm_o = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: drives RF read addresses, registers decoded payload into ID/EX, detects load-use.
// Latency: 1 cycle from if_valid & if_ready to ex_valid.
// Backpressure: ID/EX holds while ex_valid & !ex_ready (if_ready = 0); load-use inserts one bubble.
// Ports: clk/rst (sync, active-high), flush; fetch side if_valid/if_ready/if_pc/if_insn;
//        rf_addr_rd1/2 out, rf_data_rd1/2 in; hazard hz_ex_load/hz_ex_rd; EX side ex_valid/ex_ready + ex_* payload.
// Build option: ILLEGAL_INSN_TRAP_EN flags unrecognised encodings via ex_illegal instead of decoding them as NOP.
module id_stage
    import my_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [DATA_WIDTH-1:0] if_pc,
    input  logic [31:0]           if_insn,
    output logic [4:0]            rf_addr_rd1,
    output logic [4:0]            rf_addr_rd2,
    input  logic [DATA_WIDTH-1:0] rf_data_rd1,
    input  logic [DATA_WIDTH-1:0] rf_data_rd2,
    input  logic                  hz_ex_load,
    input  logic [4:0]            hz_ex_rd,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_val,
    output logic [DATA_WIDTH-1:0] ex_rs2_val,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [4:0]            ex_rs1,
    output logic [4:0]            ex_rs2,
    output logic [4:0]            ex_rd,
    output logic [3:0]            ex_alu_op,
    output logic                  ex_wr_en,
    output logic                  ex_is_load,
    output logic                  ex_is_store,
    output logic                  ex_is_branch,
    output logic                  ex_is_jump,
    output logic                  ex_illegal
);

    logic       valid_q, valid_d;
    id_ex_t     pay_q, pay_d;
    id_ex_t     dec;
    logic       use_rs1, use_rs2, legal;
    logic       stall, load_en;
    logic [DATA_WIDTH-1:0] imm;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = if_insn[6:0];
    assign f3     = if_insn[14:12];
    assign f7     = if_insn[31:25];

    // Read addresses come straight from the word; the RF returns data the same cycle.
    assign rf_addr_rd1 = if_insn[19:15];
    assign rf_addr_rd2 = if_insn[24:20];

    imm_gen u_imm_gen (
        .insn_i (if_insn),
        .imm_o  (imm)
    );

    always_comb begin
        dec         = '0;
        dec.pc      = if_pc;
        dec.rs1_val = rf_data_rd1;
        dec.rs2_val = rf_data_rd2;
        dec.imm     = imm;
        dec.rs1     = if_insn[19:15];
        dec.rs2     = if_insn[24:20];
        dec.rd      = if_insn[11:7];
        dec.alu_op  = ALU_ADD;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        legal       = 1'b0;

        case (opcode)
            OPC_LUI: begin
                legal      = 1'b1;
                dec.wr_en  = 1'b1;
                dec.alu_op = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                dec.wr_en = 1'b1;
            end
            OPC_JAL: begin
                legal       = 1'b1;
                dec.wr_en   = 1'b1;
                dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                legal       = (f3 == 3'd0);
                use_rs1     = 1'b1;
                dec.wr_en   = 1'b1;
                dec.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                legal         = (f3 != 3'd2) && (f3 != 3'd3);
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.is_branch = 1'b1;
                // EQ/NE compare via subtract, signed and unsigned ordering via SLT/SLTU.
                case (f3[2:1])
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: dec.alu_op = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                legal       = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                use_rs1     = 1'b1;
                dec.wr_en   = 1'b1;
                dec.is_load = 1'b1;
            end
            OPC_STORE: begin
                legal        = (f3 <= 3'd2);
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.is_store = 1'b1;
            end
            OPC_OP_IMM: begin
                legal     = 1'b1;
                use_rs1   = 1'b1;
                dec.wr_en = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = ALU_ADD;
                    3'd1: begin
                        legal      = (f7 == 7'h00);
                        dec.alu_op = ALU_SLL;
                    end
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: begin
                        legal      = (f7 == 7'h00) || (f7 == 7'h20);
                        dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                    end
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec.wr_en = 1'b1;
                legal     = (f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                case (f3)
                    3'd0: dec.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                    3'd1: dec.alu_op = ALU_SLL;
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Writes to x0 are architecturally discarded.
        if (dec.rd == 5'd0) begin
            dec.wr_en = 1'b0;
        end

        // An unrecognised word must not create a hazard or any side effect.
        if (!legal) begin
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
            dec.alu_op    = ALU_ADD;
            dec.wr_en     = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
`ifdef ILLEGAL_INSN_TRAP_EN
            dec.illegal   = 1'b1;
`else
            dec.imm       = '0;
`endif
        end
    end

    // x0 is never a real producer, so a load targeting it cannot cause a hazard.
    assign stall = if_valid && hz_ex_load && (hz_ex_rd != 5'd0) &&
                   ((use_rs1 && (dec.rs1 == hz_ex_rd)) ||
                    (use_rs2 && (dec.rs2 == hz_ex_rd)));

    assign load_en = !valid_q || ex_ready;

    // Flush drains the fetch offer unconditionally, so ID reports ready to discard it.
    assign if_ready = flush || (load_en && !stall);

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_en) begin
            if (stall) begin
                valid_d = 1'b0;
            end else if (if_valid) begin
                valid_d = 1'b1;
                pay_d   = dec;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pay_q.pc;
    assign ex_rs1_val   = pay_q.rs1_val;
    assign ex_rs2_val   = pay_q.rs2_val;
    assign ex_imm       = pay_q.imm;
    assign ex_rs1       = pay_q.rs1;
    assign ex_rs2       = pay_q.rs2;
    assign ex_rd        = pay_q.rd;
    assign ex_alu_op    = pay_q.alu_op;
    assign ex_wr_en     = pay_q.wr_en;
    assign ex_is_load   = pay_q.is_load;
    assign ex_is_store  = pay_q.is_store;
    assign ex_is_branch = pay_q.is_branch;
    assign ex_is_jump   = pay_q.is_jump;
    // Only ever set when the trap build is enabled; otherwise held at 0 by decode.
    assign ex_illegal   = pay_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, if_ready;
    logic [31:0] if_pc, if_insn;
    logic [4:0]  rf_addr_rd1, rf_addr_rd2;
    logic [31:0] rf_data_rd1, rf_data_rd2;
    logic        hz_ex_load;
    logic [4:0]  hz_ex_rd;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_wr_en, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ILLEGAL_INSN_TRAP_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    always #5 clk = ~clk;

    // Register-file model: value encodes the read address so operand routing is visible.
    always_comb begin
        rf_data_rd1 = 32'hA000_0000 | {27'd0, rf_addr_rd1};
        rf_data_rd2 = 32'hB000_0000 | {27'd0, rf_addr_rd2};
    end

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_insn(if_insn),
        .rf_addr_rd1(rf_addr_rd1), .rf_addr_rd2(rf_addr_rd2),
        .rf_data_rd1(rf_data_rd1), .rf_data_rd2(rf_data_rd2),
        .hz_ex_load(hz_ex_load), .hz_ex_rd(hz_ex_rd),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {wr_en, is_load, is_store, is_branch, is_jump}
    typedef struct {
        logic [31:0] insn;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu;
        logic [4:0]  flags;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{32'h00700293, 32'h00000007, 5'd5,  5'd0,  5'd7,  4'd0,  5'b10000, 1'b0}; // addi x5,x0,7
        vecs[1]  = '{32'h00128333, 32'h00000000, 5'd6,  5'd5,  5'd1,  4'd0,  5'b10000, 1'b0}; // add x6,x5,x1
        vecs[2]  = '{32'h403103B3, 32'h00000000, 5'd7,  5'd2,  5'd3,  4'd1,  5'b10000, 1'b0}; // sub x7,x2,x3
        vecs[3]  = '{32'hFFC12403, 32'hFFFFFFFC, 5'd8,  5'd2,  5'd28, 4'd0,  5'b11000, 1'b0}; // lw x8,-4(x2)
        vecs[4]  = '{32'h00512423, 32'h00000008, 5'd8,  5'd2,  5'd5,  4'd0,  5'b00100, 1'b0}; // sw x5,8(x2)
        vecs[5]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd25, 5'd1,  5'd2,  4'd1,  5'b00010, 1'b0}; // beq x1,x2,-8
        vecs[6]  = '{32'h12345537, 32'h12345000, 5'd10, 5'd8,  5'd3,  4'd10, 5'b10000, 1'b0}; // lui x10,0x12345
        vecs[7]  = '{32'hFFFFF597, 32'hFFFFF000, 5'd11, 5'd31, 5'd31, 4'd0,  5'b10000, 1'b0}; // auipc x11,0xfffff
        vecs[8]  = '{32'h001000EF, 32'h00000800, 5'd1,  5'd0,  5'd1,  4'd0,  5'b10001, 1'b0}; // jal x1,+2048
        vecs[9]  = '{32'hFFFFF06F, 32'hFFFFFFFE, 5'd0,  5'd31, 5'd31, 4'd0,  5'b00001, 1'b0}; // jal x0,-2
        vecs[10] = '{32'h00008067, 32'h00000000, 5'd0,  5'd1,  5'd0,  4'd0,  5'b00001, 1'b0}; // jalr x0,0(x1)
        vecs[11] = '{32'h4036D613, 32'h00000403, 5'd12, 5'd13, 5'd3,  4'd7,  5'b10000, 1'b0}; // srai x12,x13,3
        vecs[12] = '{32'hFFF7B713, 32'hFFFFFFFF, 5'd14, 5'd15, 5'd31, 4'd4,  5'b10000, 1'b0}; // sltiu x14,x15,-1
        vecs[13] = '{32'hFFFFFFFF, 32'h00000000, 5'd31, 5'd31, 5'd31, 4'd0,  5'b00000, ILL };  // bad opcode
        vecs[14] = '{32'h02000033, 32'h00000000, 5'd0,  5'd0,  5'd0,  4'd0,  5'b00000, ILL };  // bad funct7
        vecs[15] = '{32'h00000013, 32'h00000000, 5'd0,  5'd0,  5'd0,  4'd0,  5'b00000, 1'b0}; // nop

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = 32'h0; if_insn = 32'h0;
        hz_ex_load = 1'b0; hz_ex_rd = 5'd0; ex_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        if_insn = 32'h00128333;
        #1;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset ex_pc", ex_pc, 32'd0);
        chk("reset ex_imm", ex_imm, 32'd0);
        chk("reset flags", {27'd0, ex_wr_en, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump}, 32'd0);
        chk("reset if_ready", {31'd0, if_ready}, 32'd1);
        chk("rf_addr_rd1 idle", {27'd0, rf_addr_rd1}, 32'd5);
        chk("rf_addr_rd2 idle", {27'd0, rf_addr_rd2}, 32'd1);

        // Back-to-back decode table, one instruction per cycle.
        for (int i = 0; i < 16; i++) begin
            if_valid = 1'b1;
            if_insn  = vecs[i].insn;
            if_pc    = 32'h100 + 32'(i) * 4;
            #1;
            chk($sformatf("v%0d if_ready", i), {31'd0, if_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("v%0d ex_pc", i), ex_pc, 32'h100 + 32'(i) * 4);
            chk($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].imm);
            chk($sformatf("v%0d ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d ex_rs1", i), {27'd0, ex_rs1}, {27'd0, vecs[i].rs1});
            chk($sformatf("v%0d ex_rs2", i), {27'd0, ex_rs2}, {27'd0, vecs[i].rs2});
            chk($sformatf("v%0d ex_rs1_val", i), ex_rs1_val, 32'hA000_0000 | {27'd0, vecs[i].rs1});
            chk($sformatf("v%0d ex_rs2_val", i), ex_rs2_val, 32'hB000_0000 | {27'd0, vecs[i].rs2});
            chk($sformatf("v%0d ex_alu_op", i), {28'd0, ex_alu_op}, {28'd0, vecs[i].alu});
            chk($sformatf("v%0d flags", i),
                {27'd0, ex_wr_en, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump},
                {27'd0, vecs[i].flags});
            chk($sformatf("v%0d ex_illegal", i), {31'd0, ex_illegal}, {31'd0, vecs[i].ill});
        end

        // Load-use on rs1: one bubble, then accepted.
        hz_ex_load = 1'b1; hz_ex_rd = 5'd5;
        if_insn = 32'h00128333; if_pc = 32'h200;
        #1;
        chk("lu rs1 if_ready", {31'd0, if_ready}, 32'd0);
        tick();
        chk("lu bubble ex_valid", {31'd0, ex_valid}, 32'd0);
        hz_ex_load = 1'b0;
        #1;
        chk("lu release if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("lu accept ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu accept ex_rd", {27'd0, ex_rd}, 32'd6);
        chk("lu accept ex_pc", ex_pc, 32'h200);

        // Load-use on rs2 of an R-type stalls too.
        hz_ex_load = 1'b1; hz_ex_rd = 5'd1;
        #1;
        chk("lu rs2 if_ready", {31'd0, if_ready}, 32'd0);
        // I-format does not read its rs2 field (7 here).
        hz_ex_rd = 5'd7; if_insn = 32'h00700293;
        #1;
        chk("no rs2 use if_ready", {31'd0, if_ready}, 32'd1);

        // Load into x0 is not a hazard.
        hz_ex_rd = 5'd0; if_insn = 32'h00000333; if_pc = 32'h204;
        #1;
        chk("x0 load if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("x0 load ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("x0 load ex_rd", {27'd0, ex_rd}, 32'd6);
        hz_ex_load = 1'b0;

        // EX backpressure for 3 cycles: payload frozen.
        ex_ready = 1'b0; if_insn = 32'h12345537; if_pc = 32'h208;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d if_ready", k), {31'd0, if_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d ex_valid", k), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("bp%0d ex_pc", k), ex_pc, 32'h204);
            chk($sformatf("bp%0d ex_rd", k), {27'd0, ex_rd}, 32'd6);
            chk($sformatf("bp%0d ex_rs1_val", k), ex_rs1_val, 32'hA000_0000);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp release if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("bp release ex_rd", {27'd0, ex_rd}, 32'd10);
        chk("bp release ex_pc", ex_pc, 32'h208);

        // Flush together with a stall.
        hz_ex_load = 1'b1; hz_ex_rd = 5'd5;
        if_insn = 32'h00128333; if_pc = 32'h20C; flush = 1'b1;
        #1;
        chk("flush if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0; hz_ex_load = 1'b0;

        // Reset while a capture is being offered.
        if_insn = 32'h12345537; if_pc = 32'h210;
        tick();
        chk("pre-rst ex_valid", {31'd0, ex_valid}, 32'd1);
        rst = 1'b1; if_insn = 32'h00700293; if_pc = 32'h214;
        tick();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst ex_pc", ex_pc, 32'd0);
        chk("rst ex_imm", ex_imm, 32'd0);
        chk("rst ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst ex_rs1_val", ex_rs1_val, 32'd0);
        chk("rst ex_alu_op", {28'd0, ex_alu_op}, 32'd0);
        chk("rst flags", {26'd0, ex_wr_en, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal}, 32'd0);
        rst = 1'b0; if_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipeline. It sits between fetch and execute and owns the read side of the register file: it drives the two read addresses, captures the returned operands, immediate and control into the ID/EX pipeline register, and detects load-use hazards. It uses a valid/ready handshake on both sides and inserts a bubble on a load-use stall.

## Interface
- DATA_WIDTH, 32, operand/PC width (matches register file)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill: drop instruction in ID/EX register and the one offered by fetch
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  ID accepts this cycle
- if_pc  in  DATA_WIDTH  PC of offered instruction
- if_insn  in  32  offered instruction word
- rf_addr_rd1 / rf_addr_rd2  out  5  register-file read addresses
- rf_data_rd1 / rf_data_rd2  in  DATA_WIDTH  register-file read data (combinational, WB-forwarded)
- hz_ex_load  in  1  instruction now in EX is a load
- hz_ex_rd  in  5  destination of that instruction
- ex_valid  out  1  ID/EX register holds an instruction
- ex_ready  in  1  EX accepts this cycle
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  DATA_WIDTH  registered PC, operands, sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices
- ex_alu_op  out  4  alu_op_t
- ex_wr_en, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump  out  1  control flags
- ex_illegal  out  1  illegal-instruction flag

## Operation
- rf_addr_rd1 = if_insn[19:15], rf_addr_rd2 = if_insn[24:20], driven combinationally every cycle regardless of if_valid.
- Register-file write forwarding covers the same-cycle WB case, so no WB bypass is needed here.
- Operand use: rs1 is used by all formats except U and J. rs2 is used only by R, S and B.
- stall = if_valid & hz_ex_load & (hz_ex_rd != 0) & ((use_rs1 & rs1 == hz_ex_rd) | (use_rs2 & rs2 == hz_ex_rd)).
- load_en = !ex_valid | ex_ready.
- if_ready = load_en & !stall.
- Next-state priority, highest first:
  - rst: all ex_* outputs cleared to 0.
  - flush: ex_valid <= 0. if_ready is forced to 1 and the offered instruction is discarded.
  - load_en & stall: bubble, ex_valid <= 0, payload held.
  - load_en & if_valid: capture decode, ex_valid <= 1.
  - load_en & !if_valid: ex_valid <= 0.
  - otherwise hold.
- Decode rules:
  - ex_wr_en = 0 when rd == 0 and for S and B formats.
  - ex_imm is sign-extended per I/S/B/U/J format.
  - ex_imm is 0 for R-format.
  - B and J immediates include bit0 = 0.
- alu_op for loads, stores, AUIPC, JAL and JALR is ADD.
- alu_op for LUI is PASS_B.
- Payload registers load only when a valid instruction is captured. ex_valid alone qualifies the outputs.

## Timing
- Latency: 1 cycle from the if_valid & if_ready edge to ex_valid.
- Throughput: 1 instruction per cycle when ex_ready = 1 and there is no hazard.
- Load-use costs exactly 1 bubble. On the following cycle hz_ex_load deasserts and the instruction is accepted, with the operand arriving via register-file forwarding.
- EX backpressure (ex_valid & !ex_ready): payload held stable and if_ready = 0.
- Reset mid-operation: the in-flight instruction is lost and ex_valid = 0 the cycle after rst.
- Flush takes priority over stall and over capture in the same cycle.

## Configuration
- ILLEGAL_INSN_TRAP_EN defined:
  - An unrecognised opcode/funct3/funct7 sets ex_illegal = 1 and clears ex_wr_en, ex_is_load, ex_is_store, ex_is_branch and ex_is_jump.
  - ex_valid still asserts.
- ILLEGAL_INSN_TRAP_EN undefined:
  - ex_illegal is tied to 0.
  - Unrecognised encodings decode as NOP: all flags 0, alu_op ADD, imm 0.

## Structure
- Shared package (my_pkg) holds:
  - DATA_WIDTH
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - enum alu_op_t, 4-bit: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
  - packed struct id_ex_t for the registered payload
- One sub-module, imm_gen: combinational format select and sign extension.

## Test plan
- Pipeline capture: addi x5,x0,7 (0x00700293) with if_valid = 1 and ex_ready = 1.
  - Next cycle: ex_valid = 1, ex_rd = 5, ex_imm = 7, ex_wr_en = 1, alu_op = ADD.
- Load-use stall: hz_ex_load = 1, hz_ex_rd = 5, offer add x6,x5,x1.
  - Required: if_ready = 0 and one bubble (ex_valid = 0).
  - Accepted the next cycle once hz_ex_load = 0.
- x0 load is not a hazard: hz_ex_load = 1, hz_ex_rd = 0, offer add x6,x0,x0.
  - Required: no stall, accepted immediately.
- Backpressure: hold ex_ready = 0 for 3 cycles with ex_valid = 1.
  - Required: payload unchanged and if_ready = 0 throughout.
- Flush and reset priority:
  - Flush asserted together with a stall: ex_valid = 0 next cycle and if_ready = 1.
  - rst during capture: all ex_* outputs 0 the next cycle.
- Illegal encoding: offer 0xFFFFFFFF.
  - With ILLEGAL_INSN_TRAP_EN: ex_illegal = 1, ex_wr_en = 0.
  - Without it: ex_illegal = 0 and all flags 0.
